// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory store buffer.
package mips_mem_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int DMEM_BYTES = 512;

  // One posted store waiting to be written into D_Memory.
  typedef struct packed {
    logic              byte_acc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sb_entry_t;

  // Word accesses must sit on a 4-byte boundary; byte accesses never misalign.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic is_byte);
    return !is_byte && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store buffer with a parallel word-address compare against all live entries.
module store_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  sb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic [ADDR_W-3:0]          cmp_word,
  output sb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       hit
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] offset;
  logic             do_push;
  logic             do_pop;
  sb_entry_t        entries [DEPTH];

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0) && !push;
  assign head    = entries[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  // Flag any live entry in the same 32-bit word as the incoming load, ignoring byte lanes.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if (({1'b0, offset} < count) && (entries[i].addr[ADDR_W-1:2] == cmp_word)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Load/store front end for D_Memory: posts stores into a FIFO, drains them in idle cycles,
// and services loads directly with one cycle of latency.
module mem_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DMEM_BYTES = mips_mem_pkg::DMEM_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        align_err,
  output logic        sb_empty,
  output logic [31:0] read,
  output logic [31:0] write,
  output logic [31:0] wdata,
  output logic        en,
  output logic        byte_en,
  input  logic [31:0] data
);

  localparam logic [31:0] WORD_LIMIT = 32'(DMEM_BYTES - 4);
  localparam logic [31:0] BYTE_LIMIT = 32'(DMEM_BYTES);

  logic                   req_err;
  logic                   hazard;
  logic                   fifo_full;
  logic                   accept;
  logic                   load_acc;
  logic                   store_acc;
  logic                   drain;
  logic [$clog2(DEPTH):0] count;
  sb_entry_t              head;
  sb_entry_t              push_entry;

  assign req_err = req_byte ? (req_addr >= BYTE_LIMIT)
                            : (is_misaligned(req_addr[1:0], req_byte) || (req_addr > WORD_LIMIT));

  // Erroring requests are always taken so they can be dropped without blocking the pipe.
  assign req_ready = req_err || (req_we ? !fifo_full : !hazard);

  assign accept    = req_valid && req_ready;
  assign load_acc  = accept && !req_we && !req_err;
  assign store_acc = accept && req_we && !req_err;
  assign drain     = !accept && (count != '0) && !rst;
  assign sb_empty  = (count == '0);

  assign push_entry = '{byte_acc: req_byte, addr: req_addr, wdata: req_wdata};

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_store_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (store_acc),
    .push_entry (push_entry),
    .pop        (drain),
    .cmp_word   (req_addr[31:2]),
    .head       (head),
    .count      (count),
    .full       (fifo_full),
    .hit        (hazard)
  );

  // Memory port mux: an accepted load owns the port, otherwise the head store drains.
  always_comb begin
    en      = 1'b0;
    byte_en = 1'b0;
    read    = '0;
    write   = '0;
    wdata   = '0;
    if (load_acc) begin
      read    = req_addr;
      byte_en = req_byte;
    end else if (drain) begin
      en      = 1'b1;
      write   = head.addr;
      wdata   = head.wdata;
      byte_en = head.byte_acc;
    end
  end

  // Capture load data and raise the single-cycle response and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      align_err <= 1'b0;
    end else begin
      rsp_valid <= load_acc;
      align_err <= accept && req_err;
      if (load_acc) begin
        rsp_data <= req_byte ? {24'h0, data[7:0]} : data;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer with a D_Memory stand-in and a reference model.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        align_err;
  logic        sb_empty;
  logic [31:0] read;
  logic [31:0] write;
  logic [31:0] wdata;
  logic        en;
  logic        byte_en;
  logic [31:0] data;

  int total;
  int bad;
  int wr_in_rst;
  int ridx;

  logic [7:0] dmem    [512];
  logic [7:0] ref_mem [512];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        b;
  } pend_t;
  pend_t pq[$];

  logic        obs_ready;
  logic        obs_rsp_valid;
  logic [31:0] obs_rsp_data;
  logic        obs_align_err;
  logic        obs_sb_empty;
  logic [31:0] obs_read;
  logic [31:0] obs_write;
  logic [31:0] obs_wdata;
  logic        obs_en;
  logic        obs_byte_en;

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .align_err (align_err),
    .sb_empty  (sb_empty),
    .read      (read),
    .write     (write),
    .wdata     (wdata),
    .en        (en),
    .byte_en   (byte_en),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // D_Memory stand-in: combinational little-endian read.
  always_comb begin
    ridx = int'(read[8:0]);
    if (byte_en) data = {24'h0, dmem[ridx]};
    else data = {dmem[(ridx + 3) & 511], dmem[(ridx + 2) & 511], dmem[(ridx + 1) & 511], dmem[ridx]};
  end

  // D_Memory stand-in: synchronous write, also noting any write attempted under reset.
  always @(posedge clk) begin
    if (en) begin
      if (rst) wr_in_rst = wr_in_rst + 1;
      if (byte_en) dmem[int'(write[8:0])] = wdata[7:0];
      else for (int k = 0; k < 4; k++) dmem[(int'(write[8:0]) + k) & 511] = wdata[8*k +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic model_err(input logic [31:0] a, input logic b);
    if (b) return a >= 32'd512;
    return (a[1:0] != 2'b00) || (a > 32'd508);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic b);
    int i;
    i = int'(a[8:0]);
    if (b) return {24'h0, ref_mem[i]};
    return {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]};
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic b, input logic [31:0] d);
    int i;
    i = int'(a[8:0]);
    if (b) ref_mem[i] = d[7:0];
    else for (int k = 0; k < 4; k++) ref_mem[i + k] = d[8*k +: 8];
  endfunction

  // Drive one request for a cycle and capture every output mid-cycle.
  task automatic cycle(input logic v, input logic we, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_rsp_data  = rsp_data;
    obs_align_err = align_err;
    obs_sb_empty  = sb_empty;
    obs_read      = read;
    obs_write     = write;
    obs_wdata     = wdata;
    obs_en        = en;
    obs_byte_en   = byte_en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++; if (obs_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", obs_en); end
      total++; if (obs_rsp_data !== 32'h0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", obs_rsp_data); end
    end
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", obs_ready); end
    total++; if (obs_sb_empty !== 1'b1) begin bad++; $display("FAIL idle_sb_empty got=%b exp=1", obs_sb_empty); end
    total++; if (obs_en !== 1'b0) begin bad++; $display("FAIL idle_en got=%b exp=0", obs_en); end
    total++; if (obs_rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_rsp_valid got=%b exp=0", obs_rsp_valid); end
    total++; if (obs_align_err !== 1'b0) begin bad++; $display("FAIL idle_align_err got=%b exp=0", obs_align_err); end
  endtask

  task automatic test_basic_load();
    cycle(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL ld_ready got=%b exp=1", obs_ready); end
    total++; if (obs_read !== 32'h10 || obs_en !== 1'b0) begin bad++; $display("FAIL ld_port read=%h en=%b exp read=10 en=0", obs_read, obs_en); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_rsp_valid !== 1'b1) begin bad++; $display("FAIL ld_rsp_valid got=%b exp=1", obs_rsp_valid); end
    total++; if (obs_rsp_data !== 32'h13121110) begin bad++; $display("FAIL ld_rsp_data got=%h exp=13121110", obs_rsp_data); end
  endtask

  task automatic test_hazard();
    cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'hDEADBEEF);
    total++; if (obs_ready !== 1'b1 || obs_en !== 1'b0) begin bad++; $display("FAIL hz_store ready=%b en=%b exp 1/0", obs_ready, obs_en); end
    model_store(32'h20, 1'b0, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL hz_stall got=%b exp=0", obs_ready); end
    total++; if (obs_en !== 1'b1 || obs_write !== 32'h20 || obs_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL hz_drain en=%b write=%h wdata=%h exp 1/20/deadbeef", obs_en, obs_write, obs_wdata); end
    cycle(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL hz_accept got=%b exp=1", obs_ready); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== model_load(32'h20, 1'b0)) begin
      bad++; $display("FAIL hz_rsp valid=%b data=%h exp 1/%h", obs_rsp_valid, obs_rsp_data, model_load(32'h20, 1'b0)); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    logic [31:0] exp_w;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      cycle(1'b1, 1'b1, 1'b0, 32'h40 + 32'(4 * k), d);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL full_st%0d_ready got=%b exp=1", k, obs_ready); end
      if (obs_ready === 1'b1) model_store(32'h40 + 32'(4 * k), 1'b0, d);
    end
    d = $urandom;
    cycle(1'b1, 1'b1, 1'b0, 32'h50, d);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL full_5th_ready got=%b exp=0", obs_ready); end
    total++; if (obs_en !== 1'b1 || obs_write !== 32'h40) begin bad++; $display("FAIL full_drain en=%b write=%h exp 1/40", obs_en, obs_write); end
    cycle(1'b1, 1'b1, 1'b0, 32'h50, d);
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL full_5th_retry got=%b exp=1", obs_ready); end
    model_store(32'h50, 1'b0, d);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      if (k < 4) begin
        exp_w = 32'h44 + 32'(4 * k);
        total++; if (obs_en !== 1'b1 || obs_write !== exp_w) begin
          bad++; $display("FAIL full_order%0d en=%b write=%h exp 1/%h", k, obs_en, obs_write, exp_w); end
      end
    end
    total++; if (obs_sb_empty !== 1'b1) begin bad++; $display("FAIL full_sb_empty got=%b exp=1", obs_sb_empty); end
    cycle(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== model_load(32'h40, 1'b0)) begin
      bad++; $display("FAIL full_load valid=%b data=%h exp 1/%h", obs_rsp_valid, obs_rsp_data, model_load(32'h40, 1'b0)); end
  endtask

  task automatic test_byte();
    logic [31:0] d;
    d = {$urandom_range(0, 32'hFFFFFF), 8'hAB};
    cycle(1'b1, 1'b1, 1'b1, 32'h31, d);
    model_store(32'h31, 1'b1, d);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_en !== 1'b1 || obs_byte_en !== 1'b1 || obs_write !== 32'h31) begin
      bad++; $display("FAIL byte_drain en=%b byte_en=%b write=%h exp 1/1/31", obs_en, obs_byte_en, obs_write); end
    cycle(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h31, 32'h0);
    total++; if (obs_rsp_data !== 32'h3332AB30 || obs_rsp_data !== model_load(32'h30, 1'b0)) begin
      bad++; $display("FAIL byte_word_load got=%h exp=3332ab30", obs_rsp_data); end
    total++; if (obs_byte_en !== 1'b1 || obs_read !== 32'h31) begin bad++; $display("FAIL byte_load_port byte_en=%b read=%h exp 1/31", obs_byte_en, obs_read); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== 32'h000000AB) begin
      bad++; $display("FAIL byte_load valid=%b data=%h exp 1/000000ab", obs_rsp_valid, obs_rsp_data); end
  endtask

  task automatic test_align();
    cycle(1'b1, 1'b0, 1'b0, 32'h22, 32'h0);
    total++; if (obs_ready !== 1'b1 || obs_en !== 1'b0 || obs_read !== 32'h0) begin
      bad++; $display("FAIL al_word ready=%b en=%b read=%h exp 1/0/0", obs_ready, obs_en, obs_read); end
    cycle(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    total++; if (obs_align_err !== 1'b1 || obs_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL al_word_pulse err=%b rsp_valid=%b exp 1/0", obs_align_err, obs_rsp_valid); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL al_byte_ready got=%b exp=1", obs_ready); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_align_err !== 1'b1 || obs_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL al_byte_pulse err=%b rsp_valid=%b exp 1/0", obs_align_err, obs_rsp_valid); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_align_err !== 1'b0) begin bad++; $display("FAIL al_clear got=%b exp=0", obs_align_err); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h60 + 32'(4 * k), $urandom);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL rm_store%0d_ready got=%b exp=1", k, obs_ready); end
    end
    wr_in_rst = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++; if (obs_en !== 1'b0 || obs_sb_empty !== 1'b1) begin
        bad++; $display("FAIL rm_in_rst en=%b sb_empty=%b exp 0/1", obs_en, obs_sb_empty); end
    end
    rst = 1'b0;
    total++; if (wr_in_rst !== 0) begin bad++; $display("FAIL rm_writes got=%0d exp=0", wr_in_rst); end
    cycle(1'b1, 1'b0, 1'b0, 32'h60, 32'h0);
    total++; if (obs_ready !== 1'b1 || obs_en !== 1'b0) begin bad++; $display("FAIL rm_post ready=%b en=%b exp 1/0", obs_ready, obs_en); end
    for (int k = 1; k < 4; k++) begin
      if (k < 3) cycle(1'b1, 1'b0, 1'b0, 32'h60 + 32'(4 * k), 32'h0);
      else cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      total++; if (obs_rsp_valid !== 1'b1 || obs_rsp_data !== model_load(32'h60 + 32'(4 * (k - 1)), 1'b0)) begin
        bad++; $display("FAIL rm_load%0d valid=%b data=%h exp 1/%h", k - 1, obs_rsp_valid, obs_rsp_data,
                        model_load(32'h60 + 32'(4 * (k - 1)), 1'b0)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] bounds [8];
    logic        v, we, b, err, hz, exp_ready, acc, drain;
    logic [31:0] a, d;
    logic        prev_ld, prev_err;
    logic [31:0] prev_data;
    bounds = '{32'h1FC, 32'h1FD, 32'h1FF, 32'h200, 32'h1FE, 32'hFFFFFFF0, 32'h82, 32'h201};
    prev_ld = 1'b0; prev_err = 1'b0; prev_data = '0;
    pq.delete();
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) < 13) a = 32'h80 + 32'(4 * $urandom_range(0, 7)) + (b ? 32'($urandom_range(0, 3)) : 32'h0);
      else a = bounds[$urandom_range(0, 7)];
      d   = $urandom;
      err = model_err(a, b);
      hz  = 1'b0;
      foreach (pq[i]) if (pq[i].addr[31:2] == a[31:2]) hz = 1'b1;
      exp_ready = err || (we ? (pq.size() < DEPTH) : !hz);
      acc   = v && exp_ready;
      drain = !acc && (pq.size() > 0);
      cycle(v, we, b, a, d);
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd%0d_ready got=%b exp=%b", n, obs_ready, exp_ready); end
      total++; if (obs_sb_empty !== (pq.size() == 0)) begin bad++; $display("FAIL rnd%0d_sb_empty got=%b", n, obs_sb_empty); end
      total++; if (obs_rsp_valid !== prev_ld || obs_align_err !== prev_err) begin
        bad++; $display("FAIL rnd%0d_pulses rsp_valid=%b align_err=%b exp %b/%b", n, obs_rsp_valid, obs_align_err, prev_ld, prev_err); end
      if (prev_ld) begin
        total++; if (obs_rsp_data !== prev_data) begin bad++; $display("FAIL rnd%0d_rsp_data got=%h exp=%h", n, obs_rsp_data, prev_data); end
      end
      if (drain) begin
        total++; if (obs_en !== 1'b1 || obs_write !== pq[0].addr || obs_wdata !== pq[0].data || obs_byte_en !== pq[0].b) begin
          bad++; $display("FAIL rnd%0d_drain en=%b write=%h wdata=%h exp 1/%h/%h", n, obs_en, obs_write, obs_wdata, pq[0].addr, pq[0].data); end
      end else if (acc && !err && !we) begin
        total++; if (obs_en !== 1'b0 || obs_read !== a || obs_byte_en !== b) begin
          bad++; $display("FAIL rnd%0d_loadport en=%b read=%h exp 0/%h", n, obs_en, obs_read, a); end
      end else begin
        total++; if (obs_en !== 1'b0 || obs_read !== 32'h0 || obs_write !== 32'h0) begin
          bad++; $display("FAIL rnd%0d_idleport en=%b read=%h write=%h exp 0/0/0", n, obs_en, obs_read, obs_write); end
      end
      prev_ld   = acc && !err && !we;
      prev_err  = acc && err;
      prev_data = model_load(a, b);
      if (acc && !err && we) begin
        pq.push_back('{addr: a, data: d, b: b});
        model_store(a, b, d);
      end else if (drain) begin
        void'(pq.pop_front());
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_rsp_valid !== prev_ld) begin bad++; $display("FAIL rnd_last_rsp got=%b exp=%b", obs_rsp_valid, prev_ld); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    wr_in_rst = 0;
    for (int i = 0; i < 512; i++) begin
      dmem[i]    = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_load();
    test_hazard();
    test_fifo_full();
    test_byte();
    test_align();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
